// File: rtl/data_mem_bus_pkg.sv
// Shared constants and types for the data-side memory/I-O bus.
// Optional feature macro: DATA_MEM_BUS_CYCLE_COUNTER_EN (cycle counter register).
package data_mem_bus_pkg;

    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;
    localparam logic [31:0] OFF_CON_DATA = 32'h0000_0000;
    localparam logic [31:0] OFF_CON_STAT = 32'h0000_0004;
    localparam logic [31:0] OFF_CYCLE    = 32'h0000_0008;

    localparam logic [31:0] CON_DATA_ADDR = MMIO_BASE + OFF_CON_DATA;
    localparam logic [31:0] CON_STAT_ADDR = MMIO_BASE + OFF_CON_STAT;
    localparam logic [31:0] CYCLE_ADDR    = MMIO_BASE + OFF_CYCLE;

    // CON_STAT layout: {16'b0, count[7:0], 5'b0, overflow, full, empty}
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CON_DATA,
        REG_CON_STAT,
        REG_CYCLE,
        REG_NONE
    } region_e;

endpackage

// File: rtl/data_mem_bus_tx_fifo.sv
// Parameterised synchronous FIFO feeding the console transmit port.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign count     = r_count;
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_bus.sv
// Data-side bus: byte-writable RAM, console TX FIFO and optional cycle counter.
// Define DATA_MEM_BUS_CYCLE_COUNTER_EN to build the CYCLE register.
module data_mem_bus
    import data_mem_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic              r_overflow;
    region_e           w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_stat;
    logic [31:0]       w_cycle_rd;
    logic              w_unused;

    // Byte offset bits play no part in decode.
    assign w_unused  = &{1'b0, addr[1:0]};
    assign w_ram_idx = addr[RAM_AW+1:2];

    always_comb begin
        w_region = REG_NONE;
        if (addr[31:RAM_AW+2] == '0) begin
            w_region = REG_RAM;
        end else if (addr[31:2] == CON_DATA_ADDR[31:2]) begin
            w_region = REG_CON_DATA;
        end else if (addr[31:2] == CON_STAT_ADDR[31:2]) begin
            w_region = REG_CON_STAT;
`ifdef DATA_MEM_BUS_CYCLE_COUNTER_EN
        end else if (addr[31:2] == CYCLE_ADDR[31:2]) begin
            w_region = REG_CYCLE;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (we && (w_region == REG_RAM)) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign w_push_req = we && be[0] && (w_region == REG_CON_DATA);
    assign w_pop      = tx_valid && tx_ready;
    assign tx_valid   = !w_empty;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push_req),
        .din   (wdata[7:0]),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count),
        .head  (tx_data)
    );

    // Set and clear target different addresses, so they never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (we && be[0] && (w_region == REG_CON_STAT)) begin
            r_overflow <= 1'b0;
        end
    end

    always_comb begin
        w_stat                         = '0;
        w_stat[STAT_COUNT_LSB +: 8]    = 8'(w_count);
        w_stat[STAT_OVF_BIT]           = r_overflow;
        w_stat[STAT_FULL_BIT]          = w_full;
        w_stat[STAT_EMPTY_BIT]         = w_empty;
    end

`ifdef DATA_MEM_BUS_CYCLE_COUNTER_EN
    logic [31:0] r_cycle;
    logic        w_cycle_load;

    assign w_cycle_load = we && (be == 4'hF) && (w_region == REG_CYCLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_cycle_load) begin
            r_cycle <= wdata;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    assign w_cycle_rd = r_cycle;
`else
    assign w_cycle_rd = '0;
`endif

    always_comb begin
        rdata = '0;
        case (w_region)
            REG_RAM:      rdata = r_ram[w_ram_idx];
            REG_CON_STAT: rdata = w_stat;
            REG_CYCLE:    rdata = w_cycle_rd;
            default:      rdata = '0;
        endcase
    end

endmodule
